// File: rtl/rr_index_arbiter_pkg.sv
// Shared types and constants for the round-robin index arbiter.
// The index width is fixed at 3 because the winner drives a 3-to-8 decoder.
package rr_index_arbiter_pkg;

    localparam int IDX_W = 3;
    localparam int N     = 1 << IDX_W;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Modulo-N successor; wraps N-1 back to 0 through the natural truncation of idx_t.
    function automatic idx_t next_idx(input idx_t i);
        return idx_t'(i + idx_t'(1));
    endfunction

endpackage

// File: rtl/rr_index_arbiter_rr_pick.sv
// Combinational circular priority pick: the first set request at or after i_start, wrapping mod N.
// The request vector is rotated right by i_start, priority-encoded from bit 0, then i_start is added back.
module rr_pick
    import rr_index_arbiter_pkg::*;
(
    input  logic [N-1:0] i_req,
    input  idx_t         i_start,
    output logic         o_any,
    output idx_t         o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    idx_t           w_enc;

    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_start +: N];

    // NOTE: w_enc gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        w_enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = idx_t'(i);
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = idx_t'(w_enc + i_start);

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 8 requesters with a registered winner index and valid/ready handshake.
// The winner is held stable until accepted; the requester just served drops to lowest priority.
module rr_index_arbiter
    import rr_index_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [N-1:0] req,
    output logic         grant_valid,
    input  logic         grant_ready,
    output idx_t         grant_idx,
    output idx_t         ptr
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    idx_t       r_grant_idx;
    idx_t       w_grant_idx_nxt;
    idx_t       r_ptr;
    idx_t       w_ptr_nxt;

    logic       w_handshake;
    idx_t       w_start;
    logic       w_any;
    idx_t       w_pick;

    assign w_handshake = (r_state == GRANT) && grant_ready;

    // On a handshake the next choice starts just past the accepted index, not at the old pointer.
    assign w_start = w_handshake ? next_idx(r_grant_idx) : r_ptr;

    rr_pick u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_any   (w_any),
        .o_idx   (w_pick)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_ptr_nxt       = r_ptr;

        if (clear) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_state_nxt     = GRANT;
                        w_grant_idx_nxt = w_pick;
                    end
                end
                GRANT: begin
                    if (w_handshake) begin
                        w_ptr_nxt = next_idx(r_grant_idx);
                        if (w_any) begin
                            w_grant_idx_nxt = w_pick;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    assign grant_valid = (r_state == GRANT);
    assign grant_idx   = r_grant_idx;
    assign ptr         = r_ptr;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Scoreboard bench for rr_index_arbiter: a behavioural model predicts each post-edge output,
// a monitor pops and compares those predictions independently of the stimulus thread.
module tb_rr_index_arbiter;

    typedef struct {
        logic       v;
        logic [2:0] idx;
        logic [2:0] ptr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [7:0] req;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_idx;
    logic [2:0] ptr;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    // Behavioural model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    rr_index_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .req         (req),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rd, input logic c);
        if (c) begin
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (!m_valid) begin
            if (r != 8'h00) begin
                m_valid = 1'b1;
                m_idx   = winner(r, m_ptr);
            end
        end else if (rd) begin
            m_ptr = (m_idx + 1) % 8;
            if (r != 8'h00) m_idx = winner(r, m_ptr);
            else            m_valid = 1'b0;
        end
    endtask

    // One clock of stimulus: drive after the edge, predict what the next edge produces.
    task automatic step(input logic [7:0] r, input logic rd, input logic c);
        exp_t e;
        @(posedge clk);
        #3;
        req         = r;
        grant_ready = rd;
        clear       = c;
        model_step(r, rd, c);
        e.v   = m_valid;
        e.idx = 3'(m_idx);
        e.ptr = 3'(m_ptr);
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant_valid", int'(grant_valid), int'(e.v));
                check("ptr", int'(ptr), int'(e.ptr));
                if (e.v) check("grant_idx", int'(grant_idx), int'(e.idx));
            end
        end
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        clear       = 1'b0;
        req         = 8'hFF;
        grant_ready = 1'b0;
        model_reset();

        #3;
        check("reset_valid", int'(grant_valid), 0);
        check("reset_idx", int'(grant_idx), 0);
        check("reset_ptr", int'(ptr), 0);

        req = 8'h00;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Idle with no requests
        repeat (5) step(8'h00, 1'b1, 1'b0);

        // Single requester 5: idx 5 every cycle, ptr goes to 6
        repeat (4) step(8'b0010_0000, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);

        // Full rotation 0..7,0 with ptr wrapping
        repeat (11) step(8'hFF, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b1);

        // Backpressure: idx 3 held while req[3] drops, then 7, then ptr wraps to 0
        step(8'b1000_1000, 1'b0, 1'b0);
        repeat (4) step(8'b1000_0000, 1'b0, 1'b0);
        step(8'b1000_0000, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Skip and wrap: grant 5 then ptr=6 with req 0x03 -> 0, then 1
        step(8'h00, 1'b1, 1'b1);
        step(8'b0010_0000, 1'b1, 1'b0);
        step(8'b0000_0011, 1'b1, 1'b0);
        step(8'b0000_0011, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Clear during a handshake: no pointer advance
        step(8'b0001_0000, 1'b1, 1'b0);
        step(8'b0001_0000, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b0);

        // Randomized traffic with occasional backpressure and clears
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        // Async reset mid-GRANT
        step(8'b0100_0000, 1'b0, 1'b0);
        step(8'b0100_0000, 1'b0, 1'b0);
        @(posedge clk);
        #4;
        check("pre_reset_valid", int'(grant_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", int'(grant_valid), 0);
        check("async_reset_idx", int'(grant_idx), 0);
        check("async_reset_ptr", int'(ptr), 0);
        model_reset();
        exp_q.delete();
        req = 8'h00;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) step(8'b0000_0100, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        #4;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
